// File: rtl/imem_dmem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data SRAM arbiter.
//   arb_state_t : priority FSM encoding (LSU-first or forced IFU-first)
//   *_DEF       : default geometry for the arbiter parameters
//   BE_W        : byte-enable width for the default data width
package imem_dmem_arb_pkg;

  typedef enum logic {
    PRI_LSU = 1'b0,
    PRI_IFU = 1'b1
  } arb_state_t;

  localparam int unsigned AW_DEF       = 14;
  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned MAX_WAIT_DEF = 4;
  localparam int unsigned BE_W         = DW_DEF / 8;

endpackage

// File: rtl/imem_dmem_arb.sv
// Arbitrates one single-port SRAM between the fetch (IFU) and load/store (LSU)
// ports. LSU has fixed priority; after MAX_WAIT consecutive denied IFU cycles
// the FSM forces IFU priority until the fetch is granted or withdrawn.
// Grants are same-cycle; read data returns the cycle after the grant.
//   clk, rstn                    : clock, async active-low reset
//   ifu_req/ifu_a                : fetch request and word address
//   ifu_gnt/ifu_rvld/ifu_rd      : fetch accept, response valid, data
//   lsu_req/lsu_a/lsu_we/lsu_wd  : data request, address, byte enables, wdata
//   lsu_gnt/lsu_rvld/lsu_rd      : data accept, load valid, load data
//   mem_e/mem_a/mem_we/mem_wd    : SRAM drive
//   mem_rd                       : SRAM read data (cycle after mem_e)
//   ifu_starve                   : high while IFU priority is forced
module imem_dmem_arb
  import imem_dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ifu_req,
  input  logic [AW-1:0]   ifu_a,
  output logic            ifu_gnt,
  output logic            ifu_rvld,
  output logic [DW-1:0]   ifu_rd,
  input  logic            lsu_req,
  input  logic [AW-1:0]   lsu_a,
  input  logic [DW/8-1:0] lsu_we,
  input  logic [DW-1:0]   lsu_wd,
  output logic            lsu_gnt,
  output logic            lsu_rvld,
  output logic [DW-1:0]   lsu_rd,
  output logic            mem_e,
  output logic [AW-1:0]   mem_a,
  output logic [DW/8-1:0] mem_we,
  output logic [DW-1:0]   mem_wd,
  input  logic [DW-1:0]   mem_rd,
  output logic            ifu_starve
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_nxt;
  logic          rsp_ifu, rsp_lsu;
  logic          ifu_denied;

  // Winner selection and SRAM drive
  always_comb begin
    ifu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    mem_e   = 1'b0;
    mem_a   = '0;
    mem_we  = '0;
    mem_wd  = '0;
    if (state == PRI_IFU) begin
      if (ifu_req)      ifu_gnt = 1'b1;
      else if (lsu_req) lsu_gnt = 1'b1;
    end else begin
      if (lsu_req)      lsu_gnt = 1'b1;
      else if (ifu_req) ifu_gnt = 1'b1;
    end
    if (ifu_gnt) begin
      mem_e = 1'b1;
      mem_a = ifu_a;
    end else if (lsu_gnt) begin
      mem_e  = 1'b1;
      mem_a  = lsu_a;
      mem_we = lsu_we;
      mem_wd = lsu_wd;
    end
  end

  assign ifu_denied = ifu_req & ~ifu_gnt;

  // Starvation counter and priority FSM next state
  always_comb begin
    state_nxt = state;
    wait_nxt  = '0;
    if (ifu_denied) begin
      wait_nxt = (wait_cnt == WAIT_LAST) ? wait_cnt : CW'(wait_cnt + 1'b1);
    end
    case (state)
      PRI_LSU: if (ifu_denied && (wait_cnt == WAIT_LAST)) state_nxt = PRI_IFU;
      PRI_IFU: if (ifu_gnt || !ifu_req)                   state_nxt = PRI_LSU;
      default:                                            state_nxt = PRI_LSU;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= PRI_LSU;
      wait_cnt   <= '0;
      ifu_starve <= 1'b0;
      rsp_ifu    <= 1'b0;
      rsp_lsu    <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      ifu_starve <= (state_nxt == PRI_IFU);
      rsp_ifu    <= ifu_gnt;
      rsp_lsu    <= lsu_gnt & (lsu_we == '0);
    end
  end

  // SRAM data is steered to whichever port owns the previous cycle's read
  assign ifu_rvld = rsp_ifu;
  assign lsu_rvld = rsp_lsu;
  assign ifu_rd   = rsp_ifu ? mem_rd : '0;
  assign lsu_rd   = rsp_lsu ? mem_rd : '0;

endmodule
